filter_scheduler: RTL
=====================

Name: filter_scheduler

Overview:
- Sequences one classification run over the capture buffer's read port and the bank of matched filters.
- On start, it streams all CAPTURE_LENGTH stored samples from the buffer into every matched filter in parallel, then latches each filter's match score.
- It then finds the best-scoring filter and presents a one-shot result (index, score, above-threshold flag) on a valid/ready handshake to the downstream reporter.

Parameters:
SAMPLE_DATA_WIDTH, 8, width of one stored sample
MATCH_SCORE_WIDTH, 32, width of one signed filter score
CAPTURE_LENGTH, 1000, samples per run; buffer addresses 0..CAPTURE_LENGTH-1
NUM_FILTERS, 2, number of matched filters in the bank (>=1)
RAM_READ_LATENCY, 2, cycles from address presented to read data valid
DRAIN_TIMEOUT, 4096, max cycles to wait for missing scores (used only with SCHED_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  request a run; sampled only in IDLE
busy  out  1  high from the cycle after an accepted start until REPORT completes
ram_read_addr  out  $clog2(CAPTURE_LENGTH)  capture buffer read address
ram_read_data  in  SAMPLE_DATA_WIDTH  capture buffer read data
filter_axiiv  out  1  sample valid, broadcast to all filters
filter_axiid  out  SAMPLE_DATA_WIDTH  sample data, broadcast to all filters
filter_axiov  in  NUM_FILTERS  per-filter score valid
filter_axiod  in  NUM_FILTERS*MATCH_SCORE_WIDTH  packed scores; filter i at bits [i*W +: W]
threshold  in  MATCH_SCORE_WIDTH  signed match threshold; sampled on the start accept cycle
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_index  out  $clog2(NUM_FILTERS) (min 1)  index of the best filter
result_score  out  MATCH_SCORE_WIDTH  best score, signed
result_match  out  1  best score > threshold, signed compare
result_timeout  out  1  run ended by timeout (always 0 without SCHED_TIMEOUT_EN)

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0: busy, ram_read_addr, filter_axiiv, filter_axiid, result_*. Latched scores and got-flags are cleared. A run in progress is discarded with no result.
- IDLE: start=1 -> STREAM. On that edge, latch threshold, clear got-flags, ram_read_addr<=0.
- STREAM: issue one address per cycle, 0..CAPTURE_LENGTH-1, with no gaps. An issue-valid shift register of depth RAM_READ_LATENCY tracks reads in flight.
- Each data beat drives filter_axiiv=1 and filter_axiid=ram_read_data, registered. Each beat appears exactly RAM_READ_LATENCY+1 cycles after its address.
- After issuing the last address, ram_read_addr holds at CAPTURE_LENGTH-1 and the state goes to DRAIN. The address never wraps or exceeds CAPTURE_LENGTH-1.
- Exactly CAPTURE_LENGTH beats are emitted per run.
- Score capture, in any busy state: for filter i, the first cycle with filter_axiov[i]=1 latches its score and sets got[i]. Later pulses from filter i in the same run are ignored.
- DRAIN: stay until the shift register is empty and all got bits are set, then -> COMPARE.
- COMPARE: sequential scan, one filter per cycle, i=0..NUM_FILTERS-1 (NUM_FILTERS cycles). Signed greater-than; ties keep the lower index. Missing scores (timeout case only) are skipped; if all are missing, index=0, score=0, match=0.
- REPORT: drive result_valid=1 with stable result_* fields until result_ready=1.
- On the handshake cycle: result_valid<=0, busy<=0, state -> IDLE. result_ready with result_valid=0 is ignored. result_* fields hold their values after the handshake until the next run completes.
- start while busy is ignored; no queuing.
- Minimum run latency, start to result_valid: 1 + CAPTURE_LENGTH + RAM_READ_LATENCY + 1 + filter latency + NUM_FILTERS cycles.

Optional Feature:
- Macro SCHED_TIMEOUT_EN.
- Defined: a counter starts on DRAIN entry. If all got bits are not set after DRAIN_TIMEOUT cycles, go to COMPARE using only the received scores, and set result_timeout=1 in REPORT.
- Undefined: DRAIN waits indefinitely, the counter is absent, and result_timeout is tied to 0.

Test Plan:
- Bench config CAPTURE_LENGTH=16, NUM_FILTERS=2, RAM_READ_LATENCY=2. Buffer holds i at address i; start pulse -> 16 beats with data 0..15 in order, no gaps. First beat 4 cycles after the start edge. Address stops at 15.
- Filter scores 100 and -5, threshold=50 -> result_index=0, result_score=100, result_match=1. result_valid holds for 10 cycles with result_ready=0, then clears one cycle after ready.
- Scores -20 and -20, threshold=-30 -> index=0 (tie to lower index), match=1. With threshold=-20 -> match=0.
- start pulsed mid-STREAM and during REPORT -> ignored: no extra beats, busy profile unchanged. Filter 1 pulses axiov twice with 7 then 9 -> score 7 used.
- rst_n asserted mid-STREAM at beat 8 -> all outputs 0 immediately, asynchronously. The next start produces a full 16-beat run and a correct result.
- With SCHED_TIMEOUT_EN and DRAIN_TIMEOUT=32, filter 1 never responds and filter 0 gives 3 -> result after 32 DRAIN cycles: index=0, score=3, result_timeout=1. Without the macro -> result_valid stays 0 for 1000 cycles.

Source files
------------

// File: rtl/filter_scheduler_if.sv
// Result handshake between filter_scheduler and the downstream reporter.
// Master presents a one-shot best-filter result; slave acknowledges with result_ready.
interface filter_scheduler_if #(
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int NUM_FILTERS       = 2
);
  localparam int INDEX_WIDTH = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  logic                         result_valid;
  logic                         result_ready;
  logic [INDEX_WIDTH-1:0]       result_index;
  logic [MATCH_SCORE_WIDTH-1:0] result_score;
  logic                         result_match;
  logic                         result_timeout;

  modport master (
    output result_valid, result_index, result_score, result_match, result_timeout,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_index, result_score, result_match, result_timeout,
    output result_ready
  );
endinterface

// File: rtl/filter_scheduler.sv
// Streams one capture buffer through the matched-filter bank, then reports the best score.
// Optional SCHED_TIMEOUT_EN bounds the wait for filter scores by DRAIN_TIMEOUT cycles.
module filter_scheduler #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int MATCH_SCORE_WIDTH = 32,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int NUM_FILTERS       = 2,
  parameter int RAM_READ_LATENCY  = 2,
  parameter int DRAIN_TIMEOUT     = 4096,
  localparam int ADDR_WIDTH  = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1,
  localparam int INDEX_WIDTH = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  output logic                                   busy,
  output logic [ADDR_WIDTH-1:0]                  ram_read_addr,
  input  logic [SAMPLE_DATA_WIDTH-1:0]           ram_read_data,
  output logic                                   filter_axiiv,
  output logic [SAMPLE_DATA_WIDTH-1:0]           filter_axiid,
  input  logic [NUM_FILTERS-1:0]                 filter_axiov,
  input  logic [NUM_FILTERS*MATCH_SCORE_WIDTH-1:0] filter_axiod,
  input  logic [MATCH_SCORE_WIDTH-1:0]           threshold,
  filter_scheduler_if.master                     res
);

  typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_COMPARE, S_REPORT} state_t;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(CAPTURE_LENGTH - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(NUM_FILTERS - 1);

  state_t                        state;
  logic [RAM_READ_LATENCY-1:0]   in_flight;
  logic [MATCH_SCORE_WIDTH-1:0]  threshold_q;
  logic [MATCH_SCORE_WIDTH-1:0]  scores [NUM_FILTERS];
  logic [NUM_FILTERS-1:0]        got;
  logic [INDEX_WIDTH-1:0]        cmp_idx;
  logic                          best_found;
  logic [INDEX_WIDTH-1:0]        best_idx;
  logic [MATCH_SCORE_WIDTH-1:0]  best_score;
  logic                          take;
  logic                          nxt_found;
  logic [INDEX_WIDTH-1:0]        nxt_idx;
  logic [MATCH_SCORE_WIDTH-1:0]  nxt_score;
  logic                          issue;
  logic                          drain_done;
  logic                          drain_expire;
  logic                          timed_out;

  assign issue      = (state == S_STREAM);
  assign drain_done = (in_flight == '0) && (&got);

  // Read pipeline: one flag per read in flight; the oldest flag marks valid RAM data.
  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight    <= '0;
      filter_axiiv <= 1'b0;
      filter_axiid <= '0;
    end else begin
      in_flight    <= (in_flight << 1) | RAM_READ_LATENCY'(issue);
      filter_axiiv <= in_flight[RAM_READ_LATENCY-1];
      if (in_flight[RAM_READ_LATENCY-1]) filter_axiid <= ram_read_data;
    end
  end

  // First score pulse per filter wins; repeats within the run are ignored.
  // NOTE: the score bank is small and must read as zero after reset, so it is reset like any flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) scores[i] <= '0;
    end else if (state == S_IDLE) begin
      if (start) got <= '0;
    end else begin
      for (int i = 0; i < NUM_FILTERS; i++) begin
        if (filter_axiov[i] && !got[i]) begin
          got[i]    <= 1'b1;
          scores[i] <= filter_axiod[i*MATCH_SCORE_WIDTH +: MATCH_SCORE_WIDTH];
        end
      end
    end
  end

  // One candidate per compare cycle; strict greater-than keeps the lower index on ties.
  // NOTE: every output of this block gets a value on every path, so no latch can be inferred.
  always_comb begin
    take      = got[cmp_idx] &&
                (!best_found || ($signed(scores[cmp_idx]) > $signed(best_score)));
    nxt_found = best_found | take;
    nxt_idx   = take ? cmp_idx : best_idx;
    nxt_score = take ? scores[cmp_idx] : best_score;
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TIMER_WIDTH = $clog2(DRAIN_TIMEOUT + 1);

  logic [TIMER_WIDTH-1:0] drain_cnt;
  logic                   timed_out_q;

  assign drain_expire = (state == S_DRAIN) && (drain_cnt == TIMER_WIDTH'(DRAIN_TIMEOUT - 1));
  assign timed_out    = timed_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      if (state != S_DRAIN)  drain_cnt <= '0;
      else if (!drain_expire) drain_cnt <= drain_cnt + 1'b1;
      if (state == S_IDLE && start)       timed_out_q <= 1'b0;
      else if (drain_expire && !drain_done) timed_out_q <= 1'b1;
    end
  end
`else
  localparam int unused_drain_timeout = DRAIN_TIMEOUT;

  assign drain_expire = 1'b0;
  assign timed_out    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      ram_read_addr      <= '0;
      threshold_q        <= '0;
      cmp_idx            <= '0;
      best_found         <= 1'b0;
      best_idx           <= '0;
      best_score         <= '0;
      res.result_valid   <= 1'b0;
      res.result_index   <= '0;
      res.result_score   <= '0;
      res.result_match   <= 1'b0;
      res.result_timeout <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_STREAM;
            busy          <= 1'b1;
            ram_read_addr <= '0;
            threshold_q   <= threshold;
          end
        end
        S_STREAM: begin
          if (ram_read_addr == LAST_ADDR) state <= S_DRAIN;
          else                            ram_read_addr <= ram_read_addr + 1'b1;
        end
        S_DRAIN: begin
          if (drain_done || drain_expire) begin
            state      <= S_COMPARE;
            cmp_idx    <= '0;
            best_found <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
          end
        end
        S_COMPARE: begin
          best_found <= nxt_found;
          best_idx   <= nxt_idx;
          best_score <= nxt_score;
          if (cmp_idx == LAST_IDX) begin
            state              <= S_REPORT;
            res.result_valid   <= 1'b1;
            res.result_index   <= nxt_idx;
            res.result_score   <= nxt_score;
            res.result_match   <= nxt_found && ($signed(nxt_score) > $signed(threshold_q));
            res.result_timeout <= timed_out;
          end else begin
            cmp_idx <= cmp_idx + 1'b1;
          end
        end
        S_REPORT: begin
          if (res.result_ready) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            res.result_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
